// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback queue.
package wb_pkg;
  localparam int DATA_W_DFLT = 64;
  localparam int ADDR_W_DFLT = 4;
  localparam int NUM_REGS    = 2**ADDR_W_DFLT;

  typedef struct packed {
    logic [ADDR_W_DFLT-1:0] addr;
    logic [DATA_W_DFLT-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W_DFLT-1:0] a);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/wb_fifo_2w1r.sv
// In-order entry storage: up to two writes and one read per cycle.
// Port 0 is written ahead of port 1 when both are active.
module wb_fifo_2w1r #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 4,
  parameter  int DW    = 64,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                     gclk,
  input  logic                     grst_n,
  input  logic                     i_we0,
  input  logic [AW-1:0]            i_addr0,
  input  logic [DW-1:0]            i_data0,
  input  logic                     i_we1,
  input  logic [AW-1:0]            i_addr1,
  input  logic [DW-1:0]            i_data1,
  input  logic                     i_pop,
  output logic [AW-1:0]            o_head_addr,
  output logic [DW-1:0]            o_head_data,
  output logic [CW-1:0]            o_count,
  output logic [DEPTH-1:0][AW-1:0] o_slot_addr,
  output logic [DEPTH-1:0]         o_slot_vld
);
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr1;
  logic [CW-1:0] r_count;
  logic [1:0]    w_nwr;
  logic          w_pop;

  assign w_nwr     = {1'b0, i_we0} + {1'b0, i_we1};
  assign w_pop     = i_pop & (r_count != '0);
  assign w_wr_ptr1 = r_wr_ptr + 1'b1;

  // Storage is deliberately not reset; occupancy alone decides validity.
  always_ff @(posedge gclk) begin
    if (i_we0 | i_we1)
      r_mem[r_wr_ptr] <= i_we0 ? ent_t'({i_addr0, i_data0}) : ent_t'({i_addr1, i_data1});
    if (i_we0 & i_we1)
      r_mem[w_wr_ptr1] <= ent_t'({i_addr1, i_data1});
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_nwr);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count  <= r_count + CW'(w_nwr) - CW'(w_pop);
    end
  end

  assign o_head_addr = r_mem[r_rd_ptr].addr;
  assign o_head_data = r_mem[r_rd_ptr].data;
  assign o_count     = r_count;

  // A slot is live when its distance from the read pointer is below occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_slot_addr[i] = r_mem[i].addr;
      o_slot_vld[i]  = ({1'b0, PW'(i) - r_rd_ptr} < r_count);
    end
  end
endmodule

// File: rtl/wb_queue.sv
// Writeback queue merging load/ALU results into the register-file write port.
// Optional same-cycle load bypass when empty: define WB_BYPASS_EN.
module wb_queue
  import wb_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = DATA_W_DFLT,
  parameter  int ADDR_W = ADDR_W_DFLT,
  localparam int NREG   = 2**ADDR_W,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset_in,
  input  logic              clock_enable,
  input  logic              mmu_ready,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic [ADDR_W-1:0] regD_addr,
  output logic [DATA_W-1:0] regD_data,
  output logic              reg_write_en,
  output logic [NREG-1:0]   pending_mask,
  output logic [CW-1:0]     count
);
  logic [CW-1:0]                w_count;
  logic [ADDR_W-1:0]            w_head_addr;
  logic [DATA_W-1:0]            w_head_data;
  logic [DEPTH-1:0][ADDR_W-1:0] w_slot_addr;
  logic [DEPTH-1:0]             w_slot_vld;
  logic [NREG-1:0]              w_mask;
  logic w_ld_xfer, w_alu_xfer, w_ld_push, w_alu_push, w_pop, w_bypass, w_nempty;

  // Readiness looks only at registered occupancy, never at this cycle's pop.
  assign ld_ready   = (w_count != CW'(DEPTH));
  assign alu_ready  = (w_count <= CW'(DEPTH - 2)) | (ld_ready & ~ld_valid);

  assign w_ld_xfer  = clock_enable & ld_valid & ld_ready;
  assign w_alu_xfer = clock_enable & alu_valid & alu_ready;
  assign w_nempty   = (w_count != '0);
  assign w_pop      = clock_enable & mmu_ready;

`ifdef WB_BYPASS_EN
  assign w_bypass     = ~w_nempty & clock_enable & mmu_ready & ld_valid & (|ld_addr);
  assign regD_addr    = w_bypass ? ld_addr : w_head_addr;
  assign regD_data    = w_bypass ? ld_data : w_head_data;
  assign reg_write_en = w_bypass | w_nempty;
`else
  assign w_bypass     = 1'b0;
  assign regD_addr    = w_head_addr;
  assign regD_data    = w_head_data;
  assign reg_write_en = w_nempty;
`endif

  // Register 0 is hardwired: accept the handshake but drop the result.
  assign w_ld_push  = w_ld_xfer & (|ld_addr) & ~w_bypass;
  assign w_alu_push = w_alu_xfer & (|alu_addr);

  wb_fifo_2w1r #(.DEPTH(DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_fifo (
    .gclk        (clock),
    .grst_n      (reset_in),
    .i_we0       (w_ld_push),
    .i_addr0     (ld_addr),
    .i_data0     (ld_data),
    .i_we1       (w_alu_push),
    .i_addr1     (alu_addr),
    .i_data1     (alu_data),
    .i_pop       (w_pop),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .o_slot_addr (w_slot_addr),
    .o_slot_vld  (w_slot_vld)
  );

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_slot_vld[i]) w_mask[w_slot_addr[i]] = 1'b1;
  end

  assign pending_mask = w_mask;
  assign count        = w_count;
endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: stimulus pushes expected commits, a monitor pops them.
module tb_wb_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  a;
    logic [63:0] d;
  } ent_t;

  logic        clock, reset_in, clock_enable, mmu_ready;
  logic        ld_valid, ld_ready, alu_valid, alu_ready;
  logic [3:0]  ld_addr, alu_addr, regD_addr;
  logic [63:0] ld_data, alu_data, regD_data;
  logic        reg_write_en;
  logic [15:0] pending_mask;
  logic [2:0]  count;

  ent_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  wb_queue dut (
    .clock(clock), .reset_in(reset_in), .clock_enable(clock_enable), .mmu_ready(mmu_ready),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .regD_addr(regD_addr), .regD_data(regD_data), .reg_write_en(reg_write_en),
    .pending_mask(pending_mask), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model_mask();
    logic [15:0] m = '0;
    foreach (exp_q[i]) m |= 16'(1) << exp_q[i].a;
    return m;
  endfunction

  // One cycle: check state against the model, drive inputs, predict transfers.
  task automatic cyc(input bit ce, input bit mmu,
                     input bit ldv, input logic [3:0] lda, input logic [63:0] ldd,
                     input bit alv, input logic [3:0] ala, input logic [63:0] ald);
    int fr;
    bit lrdy, ardy, byp;
    @(negedge clock);
    chk("count", 64'(count), 64'(exp_q.size()));
    chk("pending_mask", 64'(pending_mask), 64'(model_mask()));
    fr   = DEPTH - exp_q.size();
    lrdy = (fr >= 1);
    ardy = (fr >= 2) || ((fr >= 1) && !ldv);
    byp  = 1'b0;
`ifdef WB_BYPASS_EN
    byp  = (exp_q.size() == 0) && ce && mmu && ldv && (lda != 0);
`endif
    clock_enable = ce;  mmu_ready = mmu;
    ld_valid  = ldv;  ld_addr  = lda;  ld_data  = ldd;
    alu_valid = alv;  alu_addr = ala;  alu_data = ald;
    #1;
    chk("ld_ready", 64'(ld_ready), 64'(lrdy));
    chk("alu_ready", 64'(alu_ready), 64'(ardy));
    chk("reg_write_en", 64'(reg_write_en), 64'((exp_q.size() != 0) || byp));
    if (ce && ldv && lrdy && lda != 0) exp_q.push_back('{lda, ldd});
    if (ce && alv && ardy && ala != 0) exp_q.push_back('{ala, ald});
  endtask

  task automatic idle(input bit mmu);
    cyc(1'b1, mmu, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 64'd0);
  endtask

  // Monitor: just before each edge, a commit must match the oldest expected entry.
  initial begin
    ent_t e;
    forever begin
      @(negedge clock);
      #3;
      if (reset_in && reg_write_en && mmu_ready && clock_enable) begin
        if (exp_q.size() == 0) chk("spurious_write", 64'(reg_write_en), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("regD_addr", 64'(regD_addr), 64'(e.a));
          chk("regD_data", regD_data, e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b0; clock_enable = 1'b0; mmu_ready = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    #7;
    chk("rst_wen", 64'(reg_write_en), 64'd0);
    chk("rst_mask", 64'(pending_mask), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd1);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    reset_in = 1'b1;

    // Single ALU push
    cyc(1, 0, 0, 0, 0, 1, 4'd3, 64'hAA);
    idle(1'b1);
    chk("t1_addr", 64'(regD_addr), 64'd3);
    chk("t1_mask", 64'(pending_mask), 64'h0008);
    idle(1'b0);
    chk("t1_count_after", 64'(count), 64'd0);

    // Dual push, load first
    cyc(1, 0, 1, 4'd5, 64'h11, 1, 4'd6, 64'h22);
    idle(1'b1);
    chk("t2_count2", 64'(count), 64'd2);
    chk("t2_head5", 64'(regD_addr), 64'd5);
    idle(1'b1);
    chk("t2_count1", 64'(count), 64'd1);
    chk("t2_head6", 64'(regD_addr), 64'd6);
    idle(1'b0);

    // Fill to DEPTH without draining
    cyc(1, 0, 1, 4'd1, 64'h101, 1, 4'd2, 64'h102);
    cyc(1, 0, 1, 4'd3, 64'h103, 1, 4'd4, 64'h104);
    idle(1'b0);
    chk("t3_full_ld_ready", 64'(ld_ready), 64'd0);
    chk("t3_full_alu_ready", 64'(alu_ready), 64'd0);
    idle(1'b1);
    chk("t3_pop_no_ready", 64'(ld_ready), 64'd0);
    idle(1'b0);
    chk("t3_count3", 64'(count), 64'd3);
    chk("t3_ld_ready", 64'(ld_ready), 64'd1);

    // Asynchronous reset mid-cycle with three entries queued
    #6;
    reset_in = 1'b0;
    exp_q.delete();
    #1;
    chk("t4_wen", 64'(reg_write_en), 64'd0);
    chk("t4_mask", 64'(pending_mask), 64'd0);
    chk("t4_count", 64'(count), 64'd0);
    @(negedge clock);
    #1 reset_in = 1'b1;
    cyc(1, 0, 0, 0, 0, 1, 4'd7, 64'h77);
    idle(1'b1);
    chk("t4_new_head", 64'(regD_addr), 64'd7);
    idle(1'b0);

    // Register 0 results are accepted and dropped
    cyc(1, 1, 1, 4'd0, 64'hDEAD, 1, 4'd0, 64'hBEEF);
    idle(1'b0);
    chk("t5_wen", 64'(reg_write_en), 64'd0);
    chk("t5_count", 64'(count), 64'd0);

    // Global stall holds everything
    cyc(1, 0, 1, 4'd8, 64'h88, 1, 4'd9, 64'h99);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 1, 4'd10, 64'hA0, 1, 4'd11, 64'hB0);
      chk("t6_hold_head", 64'(regD_addr), 64'd8);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

`ifdef WB_BYPASS_EN
    cyc(1, 1, 1, 4'd9, 64'h9999, 0, 0, 0);
    chk("t7_byp_wen", 64'(reg_write_en), 64'd1);
    chk("t7_byp_addr", 64'(regD_addr), 64'd9);
    idle(1'b0);
    chk("t7_byp_count", 64'(count), 64'd0);
`endif

    // Randomized traffic
    for (int k = 0; k < 600; k++)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), {$urandom, $urandom},
          $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), {$urandom, $urandom});

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1'b1);
    idle(1'b0);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Writeback queue feeding the 16x64 register file write port (regD_addr / regD_data / reg_write_en).
- Accepts results from two producers, ALU and load unit, through valid/ready handshakes, and buffers them in order in a small FIFO.
- Drains one entry per cycle, only in cycles where the register file actually commits a write.
- Exposes a pending-write mask for hazard detection in decode.

Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- DATA_W, 64: result width.
- ADDR_W, 4: register address width; 2**ADDR_W registers.

Ports:
- clock  in  1  : system clock, rising edge.
- reset_in  in  1  : asynchronous, active-low reset.
- clock_enable  in  1  : global stall; when low, no push, no pop, no state change.
- mmu_ready  in  1  : register file commits a write this cycle only when high.
- ld_valid  in  1  : load result valid.
- ld_ready  out  1  : load result accepted.
- ld_addr  in  ADDR_W  : load destination register.
- ld_data  in  DATA_W  : load result.
- alu_valid  in  1  : ALU result valid.
- alu_ready  out  1  : ALU result accepted.
- alu_addr  in  ADDR_W  : ALU destination register.
- alu_data  in  DATA_W  : ALU result.
- regD_addr  out  ADDR_W  : head-entry address.
- regD_data  out  DATA_W  : head-entry data.
- reg_write_en  out  1  : head entry valid.
- pending_mask  out  2**ADDR_W  : bit k set when any queued entry targets register k.
- count  out  log2(DEPTH)+1  : occupancy.

Behaviour:
- Reset (reset_in low, asynchronous):
  - read pointer, write pointer and count cleared to 0.
  - reg_write_en=0, pending_mask=0, ld_ready=1, alu_ready=1.
  - Entry storage is not reset.
- Defined terms:
  - free = DEPTH − count.
  - pop = clock_enable & mmu_ready & reg_write_en.
  - A transfer on either producer port occurs on a rising edge with valid & ready & clock_enable.
- Ready rules: both depend on registered state, not on pop in the same cycle.
  - ld_ready = (free ≥ 1).
  - alu_ready = (free ≥ 2) | (free ≥ 1 & !ld_valid).
- Push order: when both producers transfer in one cycle, the load entry is written first and the ALU entry second.
  - Write pointer advances by the number of entries pushed (0, 1 or 2), modulo DEPTH.
- Writes to register 0:
  - The handshake completes (ready honoured).
  - No entry is pushed and nothing is written.
  - The entry is not counted in count.
- Output side:
  - regD_addr and regD_data are driven combinationally from the head entry.
  - reg_write_en = (count ≠ 0).
  - On pop, the read pointer advances by 1.
  - Register-file commit and pop happen on the same edge, so each entry is written exactly once.
- Occupancy: count_next = count + pushes − pop. Simultaneous push and pop are legal at full and at empty.
  - Full: pop frees space only for the next cycle (no same-cycle ready).
  - Empty: with bypass disabled, a push is visible on reg_write_en one cycle later.
- Latency: minimum 1 cycle from producer transfer to reg_write_en.
- pending_mask:
  - Combinational OR of one-hot decodes of every valid entry's address.
  - A register is pending until the edge on which its last queued entry pops.
- clock_enable low: every register holds, and handshakes do not complete (ready may be high, but no transfer occurs).
- Reset mid-operation: queued entries are discarded and never reach the register file.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined:
  - When count=0, clock_enable=1, mmu_ready=1 and ld_valid with nonzero ld_addr, the load result drives regD_* directly.
  - reg_write_en=1 in the same cycle.
  - The load entry is not pushed; an ALU entry arriving in that cycle is pushed normally.
  - pending_mask does not include the bypassed entry.
- When undefined: behaviour is exactly as above, with no input-to-output combinational path.

Decomposition:
- Package wb_pkg holds:
  - DATA_W and ADDR_W defaults.
  - NUM_REGS = 2**ADDR_W.
  - A wb_entry_t typedef (addr, data).
  - A one-hot decode function.
- One natural sub-module, wb_fifo_2w1r: storage with 2-write/1-read pointers and count, parameterised by DEPTH.
- The top level holds ready logic, r0 filtering, the pending mask and the bypass.

Test Plan:
- Single ALU push: alu_addr=3, data=0xAA.
  - After the edge: reg_write_en=1, regD_addr=3, pending_mask=0x0008.
  - Next cycle with mmu_ready=1: count=0, mask=0.
- Dual push (load addr 5 / 0x11, ALU addr 6 / 0x22, same cycle):
  - Drained in order 5 then 6 over 2 cycles.
  - count goes 2→1→0.
- Fill to DEPTH=4 with mmu_ready=0:
  - ld_ready=0 and alu_ready=0.
  - Raise mmu_ready for one cycle: count=3, and ld_ready=1 on the following cycle.
- Writes to register 0 from both ports: both handshakes complete, count stays 0, reg_write_en stays 0.
- Reset: assert reset_in low asynchronously mid-cycle with count=3.
  - Outputs clear immediately: reg_write_en=0, pending_mask=0.
  - After release, the old data is never presented.
- clock_enable=0 with both producers valid and mmu_ready=1: count, pointers and outputs unchanged for 5 cycles.
- Bypass (WB_BYPASS_EN only): with the queue empty, push load addr 9 → reg_write_en=1 with regD_addr=9 in the same cycle, and count stays 0.
